// File: rtl/wb_stage_pkg.sv
// Shared load-op encodings, widths and the MEM/WB pipeline register layout.
package wb_stage_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 5;
  localparam int WB_BW = 4;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5,
    LD_LWL  = 3'd6,
    LD_LWR  = 3'd7
  } load_op_e;

  typedef struct packed {
    logic             valid;
    logic [WB_DW-1:0] pc;
    logic [WB_BW-1:0] wen;
    logic [WB_AW-1:0] waddr;
    logic [WB_DW-1:0] wdata;
    load_op_e         load_op;
    logic [1:0]       addr_lo;
  } wb_reg_t;

  // Writes to $0 are architecturally discarded; suppress them at the source.
  function automatic logic [WB_BW-1:0] gate_we(input logic valid,
                                               input logic [WB_AW-1:0] waddr,
                                               input logic [WB_BW-1:0] we);
    return (valid && (waddr != '0)) ? we : '0;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: extracts/extends the addressed byte or halfword and
// builds LWL/LWR partial words merged over the old rt value.
module load_align
  import wb_stage_pkg::*;
(
  input  load_op_e         load_op,
  input  logic [1:0]       addr_lo,
  input  logic [WB_DW-1:0] r,
  input  logic [WB_DW-1:0] old,
  output logic [WB_DW-1:0] wdata,
  output logic [WB_BW-1:0] we
);

  logic [4:0]       sh_r;
  logic [4:0]       sh_l;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WB_DW-1:0] msk_l;
  logic [WB_DW-1:0] msk_r;

  // LWR shifts right by 8*a, LWL shifts left by 8*(3-a) == 8*~a.
  assign sh_r     = {addr_lo, 3'b000};
  assign sh_l     = {~addr_lo, 3'b000};
  assign byte_sel = 8'(r >> sh_r);
  assign half_sel = addr_lo[1] ? r[31:16] : r[15:0];
  assign msk_l    = 32'hFFFF_FFFF << sh_l;
  assign msk_r    = 32'hFFFF_FFFF >> sh_r;

  always_comb begin
    wdata = old;
    we    = 4'h0;
    case (load_op)
      LD_LB: begin
        wdata = {{24{byte_sel[7]}}, byte_sel};
        we    = 4'hF;
      end
      LD_LBU: begin
        wdata = {24'h0, byte_sel};
        we    = 4'hF;
      end
      LD_LH: begin
        wdata = {{16{half_sel[15]}}, half_sel};
        we    = 4'hF;
      end
      LD_LHU: begin
        wdata = {16'h0, half_sel};
        we    = 4'hF;
      end
      LD_LW: begin
        wdata = r;
        we    = 4'hF;
      end
      LD_LWL: begin
        wdata = (r << sh_l) | (old & ~msk_l);
        we    = 4'hF << ~addr_lo;
      end
      LD_LWR: begin
        wdata = (r >> sh_r) | (old & ~msk_r);
        we    = 4'hF >> addr_lo;
      end
      default: begin
        wdata = old;
        we    = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback formatter; buffers SRAM read data
// across stalls so a stalled load keeps the value returned in its first cycle.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  input  logic [WB_DW-1:0] mem_pc,
  input  logic [WB_BW-1:0] mem_wen,
  input  logic [WB_AW-1:0] mem_waddr,
  input  logic [WB_DW-1:0] mem_wdata,
  input  logic [2:0]       mem_load_op,
  input  logic [1:0]       mem_addr_lo,
  input  logic             wb_stall,
  input  logic             wb_flush,
  input  logic [WB_DW-1:0] data_sram_rdata,
  output logic [WB_BW-1:0] we,
  output logic [WB_AW-1:0] waddr,
  output logic [WB_DW-1:0] wdata,
  output logic [WB_DW-1:0] debug_wb_pc,
  output logic [WB_BW-1:0] debug_wb_rf_wen,
  output logic [WB_AW-1:0] debug_wb_rf_wnum,
  output logic [WB_DW-1:0] debug_wb_rf_wdata
);

  wb_reg_t          r_q, r_d;
  logic             first_q, first_d;
  logic             hold_vld_q, hold_vld_d;
  logic [WB_DW-1:0] hold_data_q, hold_data_d;

  logic [WB_DW-1:0] rd_sel;
  logic [WB_DW-1:0] al_wdata;
  logic [WB_BW-1:0] al_we;
  logic [WB_BW-1:0] fmt_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      first_q     <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      r_q         <= r_d;
      first_q     <= first_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  // Flush beats stall; a stalled load grabs its read data on its first edge.
  always_comb begin
    r_d         = r_q;
    first_d     = first_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (wb_flush) begin
      r_d.valid  = 1'b0;
      first_d    = 1'b0;
      hold_vld_d = 1'b0;
    end else if (!wb_stall) begin
      r_d.valid   = mem_valid;
      r_d.pc      = mem_pc;
      r_d.wen     = mem_wen;
      r_d.waddr   = mem_waddr;
      r_d.wdata   = mem_wdata;
      r_d.load_op = load_op_e'(mem_load_op);
      r_d.addr_lo = mem_addr_lo;
      first_d     = mem_valid && (load_op_e'(mem_load_op) != LD_NONE);
      hold_vld_d  = 1'b0;
    end else if (first_q) begin
      hold_data_d = data_sram_rdata;
      first_d     = 1'b0;
      hold_vld_d  = 1'b1;
    end
  end

  assign rd_sel = hold_vld_q ? hold_data_q : data_sram_rdata;

  load_align u_load_align (
    .load_op (r_q.load_op),
    .addr_lo (r_q.addr_lo),
    .r       (rd_sel),
    .old     (r_q.wdata),
    .wdata   (al_wdata),
    .we      (al_we)
  );

  assign fmt_we = (r_q.load_op == LD_NONE) ? r_q.wen : al_we;

  assign we    = gate_we(r_q.valid, r_q.waddr, fmt_we);
  assign waddr = r_q.waddr;
  assign wdata = al_wdata;

  // Trace only the final WB cycle so a stalled instruction is logged once.
  assign debug_wb_pc       = r_q.pc;
  assign debug_wb_rf_wen   = wb_stall ? 4'h0 : we;
  assign debug_wb_rf_wnum  = r_q.waddr;
  assign debug_wb_rf_wdata = al_wdata;

endmodule

// File: doc/wb_stage.md
# wb_stage

MEM/WB pipeline register and writeback formatter. It captures the retiring instruction from MEM and merges the synchronous data-SRAM read data that returns in the WB cycle. It aligns and extends load data, including LWL/LWR partial writes. It drives the register file write port (`we[3:0]`, `waddr`, `wdata`) and the NSCSCC debug trace.

## Interface
Parameters:
- none; load-op encodings come from `defines.v`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `mem_valid` in 1: MEM holds a real instruction.
- `mem_pc` in 32: PC of the MEM instruction.
- `mem_wen` in 4: byte write-enables for non-load results (4'hF or 0).
- `mem_waddr` in 5: destination GPR.
- `mem_wdata` in 32: ALU/move result; for loads, the original rt value.
- `mem_load_op` in 3: `LD_NONE`, `LD_LB`, `LD_LBU`, `LD_LH`, `LD_LHU`, `LD_LW`, `LD_LWL`, `LD_LWR`.
- `mem_addr_lo` in 2: load address bits [1:0].
- `wb_stall` in 1: hold WB contents.
- `wb_flush` in 1: invalidate WB next edge (exception).
- `data_sram_rdata` in 32: SRAM read data; valid only in the first cycle the load occupies WB.
- `we` out 4: regfile byte enables.
- `waddr` out 5: regfile write address.
- `wdata` out 32: regfile write data.
- `debug_wb_pc` out 32: trace PC.
- `debug_wb_rf_wen` out 4: trace enables.
- `debug_wb_rf_wnum` out 5: trace register number.
- `debug_wb_rf_wdata` out 32: trace data.

## Operation
- The pipeline register (valid, pc, wen, waddr, wdata, load_op, addr_lo) loads on every edge where `wb_stall`=0.
- `wb_flush` has priority over `wb_stall`: the edge clears valid and resets `first`.
- Flag `first` is 1 in the first cycle after a load; it selects live `data_sram_rdata`.
- If `first` and `wb_stall` are both 1, the edge copies `data_sram_rdata` into `hold_data`, sets `first`=0, and sets `hold_vld`=1.
- Later cycles of the same instruction use `hold_data`.
- `hold_vld` clears when a new instruction loads or on flush.
- Load formatting uses r = selected read data and a = addr_lo:
  - LB/LBU: byte a, sign/zero-extended; `we`=F.
  - LH/LHU: halfword a[1], extended; `we`=F. a[0] is guaranteed 0 (AdEL raised upstream).
  - LW: r; `we`=F.
  - LWL: `wdata` = r << 8·(3−a); `we` = {1000, 1100, 1110, 1111} for a = 0..3.
  - LWR: `wdata` = r >> 8·a; `we` = {1111, 0111, 0011, 0001} for a = 0..3.
  - LD_NONE: `we` = registered `mem_wen`; `wdata` = registered `mem_wdata`.
- `we` is forced to 0 when valid=0 or waddr=0.
- `we` may assert for several cycles while stalled. This is safe because writes are idempotent and the regfile merges by byte.
- The debug trace mirrors `we`/`waddr`/`wdata`/pc. `debug_wb_rf_wen` is nonzero only in the last WB cycle (valid & !`wb_stall`), so each instruction is traced once.

## Timing
- Reset: all registers 0, valid=0, `first`=0, `hold_vld`=0. All outputs read 0.
- Latency: MEM→regfile write is one edge. The write commits on the following edge inside the regfile, with same-cycle bypass handled there.
- Outputs are combinational from WB registers plus `data_sram_rdata`; no extra cycle.
- Flush while stalled: valid=0 after the edge; the buffered load data is discarded.
- A reset mid-load clears `hold_vld`; no write is produced.
- Stall with a non-load: registers hold; `hold_data` is unused.

## Structure
- `LD_*` codes and the `wb` width constants go in `defines.v`.
- Sub-module `load_align`: combinational; inputs load_op, addr_lo, r, old; outputs wdata and we.
- The pipeline register uses the existing `DFFRE` cells.

## Test plan
- LW at addr_lo=0, SRAM returns 32'h8899AABB, rt=$5 → one cycle later `we`=F, `waddr`=5, `wdata`=8899AABB, and the debug wen is F.
- LB at a=2 with 8899AABB → `wdata`=FFFFFF99; LBU → 00000099; LH at a=2 → FFFF8899.
- LWL at a=1, r=11223344 → `we`=1100, `wdata`[31:16]=3344. LWR at a=1 → `we`=0111, `wdata`[23:0]=112233.
- Load in WB with `wb_stall`=1 for 3 cycles while `data_sram_rdata` changes to DEADBEEF after the first cycle → `wdata` stays the first-cycle value. The debug wen is 0 until the stall drops, then F for exactly one cycle.
- ALU result to $0 with `mem_wen`=F → `we`=0 and no trace entry.
- `wb_flush`=1 together with `wb_stall`=1 on a pending load → the next cycle valid=0, `we`=0, `hold_vld`=0. `rst_n` pulsed low mid-load → all outputs 0 immediately.
